// File: rtl/mem_scheduler_pkg.sv
// mem_scheduler_pkg: request/response structs, scheduler state and port indices for mem_scheduler
package mem_scheduler_pkg;
  typedef struct packed {
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;
  typedef struct packed {
    logic        mem_ready;
    logic [31:0] mem_rdata;
  } mem_out_type;
  typedef enum logic {IDLE, BUSY} sched_state_type;
  localparam logic [1:0] PORT_DMEM = 2'd0;
  localparam logic [1:0] PORT_DMA  = 2'd1;
  localparam logic [1:0] PORT_IMEM = 2'd2;
endpackage

// File: rtl/mem_sched_pick.sv
// mem_sched_pick: one-hot picker; starved ports outrank the rest, lower port index wins within a class
module mem_sched_pick (
  input  logic [2:0] full,
  input  logic [2:0] starved,
  output logic [2:0] grant,
  output logic       any
);
  logic [2:0] hot, cand;
  always_comb begin
    hot   = full & starved;
    cand  = |hot ? hot : full;
    grant = cand[0] ? 3'b001 : cand[1] ? 3'b010 : cand[2] ? 3'b100 : 3'b000;
    any   = |full;
  end
endmodule

// File: rtl/mem_scheduler.sv
// mem_scheduler: shares one memory port between dmem, dma and imem with one-deep slots and aging arbitration.
// Build option MEM_SCHED_TIMEOUT_EN aborts transfers that see no memory_ready for TIMEOUT_CYCLES cycles.
module mem_scheduler
  import mem_scheduler_pkg::*;
#(
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  mem_in_type  imem_in,
  output mem_out_type imem_out,
  input  mem_in_type  dmem_in,
  output mem_out_type dmem_out,
  input  mem_in_type  dma_in,
  output mem_out_type dma_out,
  output logic        memory_valid,
  output logic        memory_instr,
  output logic [31:0] memory_addr,
  output logic [31:0] memory_wdata,
  output logic [3:0]  memory_wstrb,
  input  logic [31:0] memory_rdata,
  input  logic        memory_ready,
  output logic        timeout_err
);
  if (STARVE_LIMIT < 1 || STARVE_LIMIT >= 2**CNT_W || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= 2**CNT_W) begin : g_bad_cfg
    $error("mem_scheduler: STARVE_LIMIT/TIMEOUT_CYCLES out of range for CNT_W");
  end
  sched_state_type state, state_nx;
  mem_in_type [2:0] req_in, slot;
  mem_out_type [2:0] resp;
  mem_in_type sel;
  logic [2:0] full, full_nx, freed, capture, starved, gnt;
  logic [CNT_W-1:0] age [3];
  logic [CNT_W-1:0] age_nx [3];
  logic [1:0] owner, gnt_idx;
  logic busy, done, expire, any, grant_evt;
  assign req_in  = {imem_in, dma_in, dmem_in};
  assign busy    = state == BUSY;
  assign done    = busy & (memory_ready | expire);
  assign freed   = done ? 3'b001 << owner : 3'b000;
  assign capture = {imem_in.mem_valid, dma_in.mem_valid, dmem_in.mem_valid} & (~full | freed);
  assign full_nx = capture | (full & ~freed);
  // A freed slot and any new capture compete on the same edge, so grants run back-to-back.
  assign grant_evt = any & (~busy | (done & ~expire));
  assign gnt_idx   = gnt[PORT_DMEM] ? PORT_DMEM : gnt[PORT_DMA] ? PORT_DMA : PORT_IMEM;
  mem_sched_pick u_pick (
    .full    (full_nx),
    .starved (starved),
    .grant   (gnt),
    .any     (any)
  );
  always_comb begin
    state_nx = grant_evt ? BUSY : (busy && !done) ? BUSY : IDLE;
    for (int i = 0; i < 3; i++) begin
      starved[i] = age[i] >= CNT_W'(STARVE_LIMIT);
      age_nx[i]  = (!full_nx[i] || (grant_evt && gnt[i])) ? '0 :
                   (grant_evt && age[i] != '1) ? age[i] + 1'b1 : age[i];
      resp[i].mem_ready = freed[i];
      resp[i].mem_rdata = (freed[i] && !expire) ? memory_rdata : '0;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      full  <= '0;
      owner <= PORT_DMEM;
      for (int i = 0; i < 3; i++) age[i] <= '0;
    end else begin
      state <= state_nx;
      full  <= full_nx;
      if (grant_evt) owner <= gnt_idx;
      for (int i = 0; i < 3; i++) begin
        if (capture[i]) slot[i] <= req_in[i];
        age[i] <= age_nx[i];
      end
    end
  end
`ifdef MEM_SCHED_TIMEOUT_EN
  logic [CNT_W-1:0] tcnt;
  assign expire = busy & (tcnt == CNT_W'(TIMEOUT_CYCLES)) & ~memory_ready;
  always_ff @(posedge clock) begin
    if (reset) tcnt <= '0;
    else if (grant_evt) tcnt <= CNT_W'(1);
    else if (busy) tcnt <= tcnt + 1'b1;
  end
`else
  assign expire = 1'b0;
`endif
  assign sel          = slot[owner];
  assign memory_valid = busy & sel.mem_valid;
  assign memory_instr = busy & sel.mem_instr;
  assign memory_addr  = busy ? sel.mem_addr : '0;
  assign memory_wdata = busy ? sel.mem_wdata : '0;
  assign memory_wstrb = busy ? sel.mem_wstrb : '0;
  assign timeout_err  = expire;
  assign dmem_out     = resp[PORT_DMEM];
  assign dma_out      = resp[PORT_DMA];
  assign imem_out     = resp[PORT_IMEM];
endmodule

// File: tb/tb_mem_scheduler.sv
// tb_mem_scheduler: directed scenarios plus random traffic checked every cycle against a behavioural scheduler model
module tb_mem_scheduler;
  import mem_scheduler_pkg::*;
  localparam int SL = 2;
  localparam int TO = 8;
  logic clock = 0, reset = 1;
  mem_in_type imem_in, dmem_in, dma_in;
  mem_out_type imem_out, dmem_out, dma_out;
  logic memory_valid, memory_instr, memory_ready, timeout_err;
  logic [31:0] memory_addr, memory_wdata, memory_rdata;
  logic [3:0] memory_wstrb;
  int n_cmp = 0, n_bad = 0;

  mem_scheduler #(.STARVE_LIMIT(SL), .TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clock(clock), .reset(reset),
    .imem_in(imem_in), .imem_out(imem_out),
    .dmem_in(dmem_in), .dmem_out(dmem_out),
    .dma_in(dma_in), .dma_out(dma_out),
    .memory_valid(memory_valid), .memory_instr(memory_instr), .memory_addr(memory_addr),
    .memory_wdata(memory_wdata), .memory_wstrb(memory_wstrb), .memory_rdata(memory_rdata),
    .memory_ready(memory_ready), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, a, e, $time);
    end
  endtask

  function automatic mem_in_type mk(input logic [31:0] addr, input logic instr);
    mem_in_type r;
    r.mem_valid = 1'b1;
    r.mem_instr = instr;
    r.mem_addr  = addr;
    r.mem_wdata = ~addr;
    r.mem_wstrb = addr[3:0];
    return r;
  endfunction

  // Behavioural model: ports 0=dmem,1=dma,2=imem; the winner is the full slot with the best score.
  bit m_on = 0, m_busy, m_full [3];
  mem_in_type m_slot [3], m_in [3];
  int m_age [3], m_own, m_cnt, best, bs, sc;
  bit to_hit, fin, gr;
  logic [70:0] e_bus;
  logic [98:0] e_out;
  initial forever begin
    @(negedge clock);
    m_in[0] = dmem_in; m_in[1] = dma_in; m_in[2] = imem_in;
    to_hit = 0;
`ifdef MEM_SCHED_TIMEOUT_EN
    to_hit = m_busy && m_cnt == TO && !memory_ready;
`endif
    fin = m_busy && (memory_ready || to_hit);
    if (m_on) begin
      e_bus = m_busy ? {1'b1, m_slot[m_own].mem_instr, m_slot[m_own].mem_addr,
                        m_slot[m_own].mem_wdata, m_slot[m_own].mem_wstrb, to_hit} : {70'd0, 1'b0};
      e_out = '0;
      for (int i = 0; i < 3; i++)
        if (fin && m_own == i) e_out[i*33 +: 33] = {1'b1, to_hit ? 32'd0 : memory_rdata};
      chk("model_bus", {memory_valid, memory_instr, memory_addr, memory_wdata, memory_wstrb, timeout_err}, e_bus);
      chk("model_resp", {imem_out, dma_out, dmem_out}, e_out);
    end
    if (reset) begin
      m_on = 1; m_busy = 0; m_own = 0; m_cnt = 0;
      for (int i = 0; i < 3; i++) begin m_full[i] = 0; m_age[i] = 0; end
    end else if (m_on) begin
      if (fin) m_full[m_own] = 0;
      for (int i = 0; i < 3; i++)
        if (m_in[i].mem_valid && !m_full[i]) begin m_full[i] = 1; m_slot[i] = m_in[i]; end
      best = -1; bs = -1;
      for (int i = 0; i < 3; i++) begin
        sc = (m_age[i] >= SL ? 10 : 0) + (2 - i);
        if (m_full[i] && sc > bs) begin bs = sc; best = i; end
      end
      gr = (!m_busy || (fin && !to_hit)) && best >= 0;
      for (int i = 0; i < 3; i++)
        if (!m_full[i]) m_age[i] = 0;
        else if (gr) m_age[i] = (i == best) ? 0 : (m_age[i] < 255 ? m_age[i] + 1 : 255);
      if (gr) begin m_busy = 1; m_own = best; m_cnt = 1; end
      else if (m_busy && !fin) m_cnt++;
      else m_busy = 0;
    end
  end

  task automatic cyc();
    @(posedge clock); #1;
  endtask

  task automatic quiet();
    imem_in = '0; dmem_in = '0; dma_in = '0; memory_ready = 0; memory_rdata = 32'h0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    quiet();
    reset = 1;
    repeat (3) cyc();
    @(negedge clock);
    chk("reset_bus", {memory_valid, memory_addr, timeout_err}, 34'd0);
    chk("reset_resp", {imem_out, dma_out, dmem_out}, 99'd0);
    cyc(); reset = 0;
    cyc();
    // 1: single dmem read, ready three cycles after the request
    dmem_in = mk(32'h0000_1000, 0);
    @(negedge clock); chk("t1_idle", memory_valid, 0);
    cyc(); dmem_in = '0;
    @(negedge clock); chk("t1_valid1", {memory_valid, memory_addr}, {1'b1, 32'h0000_1000});
    chk("t1_noready1", dmem_out.mem_ready, 0);
    cyc();
    @(negedge clock); chk("t1_valid2", memory_valid, 1); chk("t1_noready2", dmem_out.mem_ready, 0);
    cyc(); memory_ready = 1; memory_rdata = 32'hCAFE_0001;
    @(negedge clock); chk("t1_resp", dmem_out, {1'b1, 32'hCAFE_0001});
    cyc(); quiet();
    @(negedge clock); chk("t1_done", memory_valid, 0);
    cyc();
    // 2: all three at once, ready every cycle
    imem_in = mk(32'h0000_2000, 1); dmem_in = mk(32'h0000_2100, 0); dma_in = mk(32'h0000_2200, 0);
    @(negedge clock);
    cyc(); imem_in = '0; dmem_in = '0; dma_in = '0; memory_ready = 1; memory_rdata = 32'h2;
    @(negedge clock); chk("t2_g1", {memory_valid, memory_addr, dmem_out.mem_ready}, {1'b1, 32'h0000_2100, 1'b1});
    cyc();
    @(negedge clock); chk("t2_g2", {memory_valid, memory_addr, dma_out.mem_ready}, {1'b1, 32'h0000_2200, 1'b1});
    cyc();
    @(negedge clock); chk("t2_g3", {memory_valid, memory_instr, memory_addr, imem_out.mem_ready}, {2'b11, 32'h0000_2000, 1'b1});
    cyc(); memory_ready = 0;
    @(negedge clock); chk("t2_idle", memory_valid, 0);
    cyc();
    // 3: dmem hammers while imem waits; imem promoted after two dmem grants
    imem_in = mk(32'h0000_3F00, 1); dmem_in = mk(32'h0000_3000, 0); memory_ready = 1;
    @(negedge clock);
    cyc(); dmem_in = mk(32'h0000_3001, 0);
    @(negedge clock); chk("t3_d1", memory_addr, 32'h0000_3000);
    cyc(); dmem_in = mk(32'h0000_3002, 0);
    @(negedge clock); chk("t3_d2", memory_addr, 32'h0000_3001);
    cyc(); imem_in = '0; dmem_in = '0;
    @(negedge clock); chk("t3_imem", {memory_addr, imem_out.mem_ready}, {32'h0000_3F00, 1'b1});
    cyc();
    @(negedge clock); chk("t3_d3", memory_addr, 32'h0000_3002);
    cyc(); memory_ready = 0;
    @(negedge clock); chk("t3_idle", memory_valid, 0);
    cyc();
    // 4: re-request into a full slot is dropped
    dmem_in = mk(32'h0000_4000, 0);
    @(negedge clock);
    cyc(); dmem_in = mk(32'h0000_4444, 0);
    @(negedge clock); chk("t4_keep1", memory_addr, 32'h0000_4000);
    cyc(); dmem_in = '0;
    @(negedge clock); chk("t4_keep2", memory_addr, 32'h0000_4000);
    cyc(); memory_ready = 1; memory_rdata = 32'h4;
    @(negedge clock); chk("t4_resp", {memory_addr, dmem_out.mem_ready}, {32'h0000_4000, 1'b1});
    cyc(); memory_ready = 0;
    @(negedge clock); chk("t4_dropped", memory_valid, 0);
    cyc();
    // 5: reset while busy
    dmem_in = mk(32'h0000_5000, 0);
    @(negedge clock);
    cyc(); dmem_in = '0; reset = 1;
    @(negedge clock); chk("t5_busy", memory_valid, 1);
    cyc(); reset = 0; memory_ready = 1; memory_rdata = 32'h5;
    @(negedge clock); chk("t5_cleared", {memory_valid, imem_out.mem_ready, dma_out.mem_ready, dmem_out.mem_ready}, 4'd0);
    cyc(); memory_ready = 0; dmem_in = mk(32'h0000_5004, 0);
    @(negedge clock);
    cyc(); dmem_in = '0;
    @(negedge clock); chk("t5_again", {memory_valid, memory_addr}, {1'b1, 32'h0000_5004});
    cyc(); memory_ready = 1;
    @(negedge clock); chk("t5_resp", dmem_out.mem_ready, 1);
    cyc(); memory_ready = 0;
    cyc();
    // 6: memory never answers
    dmem_in = mk(32'h0000_6000, 0); memory_rdata = 32'hDEAD_BEEF;
    @(negedge clock);
    cyc(); dmem_in = '0;
    for (int k = 1; k < TO; k++) begin
      @(negedge clock); chk("t6_wait", {memory_valid, timeout_err, dmem_out.mem_ready}, 3'b100);
      cyc();
    end
    @(negedge clock);
`ifdef MEM_SCHED_TIMEOUT_EN
    chk("t6_abort", {timeout_err, dmem_out}, {1'b1, 1'b1, 32'd0});
`else
    chk("t6_hold", {memory_valid, timeout_err, dmem_out.mem_ready}, 3'b100);
`endif
    cyc(); memory_ready = 1;
    @(negedge clock);
`ifdef MEM_SCHED_TIMEOUT_EN
    chk("t6_late", {memory_valid, dmem_out.mem_ready}, 2'b00);
`else
    chk("t6_served", {memory_valid, dmem_out}, {2'b11, 32'hDEAD_BEEF});
`endif
    cyc(); memory_ready = 0;
    cyc();
    // random traffic, checked by the model
    for (int c = 0; c < 3000; c++) begin
      dmem_in = mk($urandom, 1'($urandom)); dmem_in.mem_valid = $urandom_range(0, 2) == 0;
      dma_in  = mk($urandom, 1'($urandom)); dma_in.mem_valid  = $urandom_range(0, 2) == 0;
      imem_in = mk($urandom, 1'($urandom)); imem_in.mem_valid = $urandom_range(0, 2) == 0;
      memory_ready = (c < 1500) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 9) == 0);
      memory_rdata = $urandom;
      reset = $urandom_range(0, 299) == 0;
      cyc();
    end
    reset = 0; quiet(); memory_ready = 1;
    repeat (10) cyc();
    quiet();
    repeat (2) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
